// File: rtl/fb_scanout_arbiter.sv
// Framebuffer RAM arbiter: display line prefetch (priority) into a ping-pong line buffer,
// with renderer writes accepted only while no prefetch is running.
module fb_scanout_arbiter #(
  parameter int unsigned HOR_ACTIVE_PIXELS = 640,
  parameter int unsigned VER_ACTIVE_PIXELS = 480,
  parameter int unsigned PIXEL_WIDTH       = 12,
  parameter int unsigned X_WIDTH           = $clog2(HOR_ACTIVE_PIXELS),
  parameter int unsigned Y_WIDTH           = $clog2(VER_ACTIVE_PIXELS),
  parameter int unsigned ADDR_WIDTH        = $clog2(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS)
) (
  input  logic                   clk_rgb,
  input  logic                   rst_n,
  input  logic                   line_start,
  input  logic [Y_WIDTH-1:0]     next_line,
  input  logic                   next_line_active,
  input  logic [X_WIDTH-1:0]     disp_x,
  output logic [PIXEL_WIDTH-1:0] disp_pixel,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [ADDR_WIDTH-1:0]  wr_addr,
  input  logic [PIXEL_WIDTH-1:0] wr_data,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic                   mem_we,
  output logic [PIXEL_WIDTH-1:0] mem_wdata,
  input  logic [PIXEL_WIDTH-1:0] mem_rdata,
  output logic                   underrun
);

  typedef enum logic [0:0] {StIdle, StFetch} state_e;

  localparam logic [X_WIDTH-1:0]    LastIdx = X_WIDTH'(HOR_ACTIVE_PIXELS - 1);
  localparam logic [ADDR_WIDTH-1:0] LineLen = ADDR_WIDTH'(HOR_ACTIVE_PIXELS);

  state_e                 state_q, state_d;
  logic                   disp_bank_q, disp_bank_d;
  logic [X_WIDTH-1:0]     count_q, count_d;
  logic [ADDR_WIDTH-1:0]  base_q, base_d;
  logic                   rd_pending_q, rd_pending_d;
  logic [X_WIDTH-1:0]     rd_idx_q, rd_idx_d;
  logic                   underrun_q, underrun_d;
  logic                   lb_we;

  logic [PIXEL_WIDTH-1:0] line_buf [2][HOR_ACTIVE_PIXELS];

  always_comb begin
    state_d      = state_q;
    disp_bank_d  = disp_bank_q;
    count_d      = count_q;
    base_d       = base_q;
    rd_pending_d = 1'b0;
    rd_idx_d     = rd_idx_q;
    underrun_d   = underrun_q;
    if (line_start) begin
      disp_bank_d = ~disp_bank_q;
      base_d      = ADDR_WIDTH'(next_line) * LineLen;
      count_d     = '0;
      state_d     = next_line_active ? StFetch : StIdle;
      if (state_q == StFetch) underrun_d = 1'b1;
    end else if (state_q == StFetch) begin
      rd_pending_d = 1'b1;
      rd_idx_d     = count_q;
      count_d      = count_q + X_WIDTH'(1);
      if (count_q == LastIdx) state_d = StIdle;
    end
  end

  // A line_start during FETCH abandons the fetch, so the read returning now is dropped.
  assign lb_we = rd_pending_q && !(line_start && (state_q == StFetch));

  always_comb begin
    wr_ready  = 1'b0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (state_q == StFetch) begin
      mem_addr = base_q + ADDR_WIDTH'(count_q);
    end else if (rst_n && !line_start) begin
      wr_ready = 1'b1;
      if (wr_valid) begin
        mem_addr  = wr_addr;
        mem_we    = 1'b1;
        mem_wdata = wr_data;
      end
    end
  end

  always_ff @(posedge clk_rgb or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      disp_bank_q  <= 1'b0;
      count_q      <= '0;
      base_q       <= '0;
      rd_pending_q <= 1'b0;
      rd_idx_q     <= '0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      disp_bank_q  <= disp_bank_d;
      count_q      <= count_d;
      base_q       <= base_d;
      rd_pending_q <= rd_pending_d;
      rd_idx_q     <= rd_idx_d;
      underrun_q   <= underrun_d;
    end
  end

  always_ff @(posedge clk_rgb) begin
    if (lb_we) line_buf[~disp_bank_q][rd_idx_q] <= mem_rdata;
  end

  always_ff @(posedge clk_rgb or negedge rst_n) begin
    if (!rst_n) begin
      disp_pixel <= '0;
    end else if (32'(disp_x) < HOR_ACTIVE_PIXELS) begin
      disp_pixel <= line_buf[disp_bank_q][disp_x];
    end else begin
      disp_pixel <= '0;
    end
  end

  assign underrun = underrun_q;

endmodule

// File: tb/tb_fb_scanout_arbiter.sv
// Directed bench for fb_scanout_arbiter: 8x4 frame, 8-bit pixels, RAM preloaded with mem[a]=a.
module tb_fb_scanout_arbiter;

  logic       clk_rgb = 1'b0;
  logic       rst_n;
  logic       line_start;
  logic [1:0] next_line;
  logic       next_line_active;
  logic [2:0] disp_x;
  logic [7:0] disp_pixel;
  logic       wr_valid;
  logic       wr_ready;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic [4:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       underrun;

  int tests = 0;
  int fails = 0;

  logic [7:0] ram [32];
  logic       ram_load;

  always #5 clk_rgb = ~clk_rgb;

  fb_scanout_arbiter #(
    .HOR_ACTIVE_PIXELS(8),
    .VER_ACTIVE_PIXELS(4),
    .PIXEL_WIDTH(8)
  ) dut (
    .clk_rgb(clk_rgb),
    .rst_n(rst_n),
    .line_start(line_start),
    .next_line(next_line),
    .next_line_active(next_line_active),
    .disp_x(disp_x),
    .disp_pixel(disp_pixel),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .mem_addr(mem_addr),
    .mem_we(mem_we),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .underrun(underrun)
  );

  // Single-port RAM with registered read data.
  always @(posedge clk_rgb) begin
    if (ram_load) begin
      for (int i = 0; i < 32; i++) ram[i] <= 8'(i);
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  task automatic tick();
    @(posedge clk_rgb);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // line_start for an active line, then check the 8 read addresses and held-off writes.
  task automatic fetch_line(input logic [1:0] line);
    next_line        = line;
    next_line_active = 1'b1;
    line_start       = 1'b1;
    tick();
    line_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("fetch_addr", 32'(mem_addr), 32'(line) * 8 + 32'(i));
      chk("fetch_wr_ready", 32'(wr_ready), 0);
      chk("fetch_we", 32'(mem_we), 0);
      tick();
    end
  endtask

  task automatic swap_idle();
    next_line_active = 1'b0;
    line_start       = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  task automatic read_px(input logic [2:0] x, input logic [7:0] exp);
    disp_x = x;
    tick();
    chk("disp_pixel", 32'(disp_pixel), 32'(exp));
  endtask

  initial begin
    rst_n            = 1'b0;
    ram_load         = 1'b1;
    line_start       = 1'b0;
    next_line        = '0;
    next_line_active = 1'b0;
    disp_x           = '0;
    wr_valid         = 1'b0;
    wr_addr          = '0;
    wr_data          = '0;
    tick();
    ram_load = 1'b0;
    tick();
    chk("rst_wr_ready", 32'(wr_ready), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_disp_pixel", 32'(disp_pixel), 0);
    chk("rst_underrun", 32'(underrun), 0);
    rst_n = 1'b1;
    #1;
    chk("idle_wr_ready", 32'(wr_ready), 1);

    // 1: fetch line 2, swap it to the front, read it back.
    fetch_line(2'd2);
    tick();
    swap_idle();
    for (int i = 0; i < 8; i++) read_px(3'(i), 8'(16 + i));

    // 2: renderer write held off during a fetch, accepted once idle.
    next_line        = 2'd1;
    next_line_active = 1'b1;
    line_start       = 1'b1;
    tick();
    line_start = 1'b0;
    wr_valid   = 1'b1;
    wr_addr    = 5'd5;
    wr_data    = 8'hAA;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("hold_wr_ready", 32'(wr_ready), 0);
      chk("hold_we", 32'(mem_we), 0);
      tick();
    end
    #1;
    chk("accept_ready", 32'(wr_ready), 1);
    chk("accept_we", 32'(mem_we), 1);
    chk("accept_addr", 32'(mem_addr), 5);
    chk("accept_wdata", 32'(mem_wdata), 32'h AA);
    tick();
    wr_valid = 1'b0;
    fetch_line(2'd0);
    tick();
    swap_idle();
    read_px(3'd5, 8'hAA);
    read_px(3'd4, 8'h04);

    // 3: line_start and wr_valid in the same idle cycle.
    wr_valid         = 1'b1;
    wr_addr          = 5'd9;
    wr_data          = 8'h55;
    next_line        = 2'd3;
    next_line_active = 1'b1;
    line_start       = 1'b1;
    #1;
    chk("conflict_ready", 32'(wr_ready), 0);
    chk("conflict_we", 32'(mem_we), 0);
    tick();
    line_start = 1'b0;
    wr_valid   = 1'b0;

    // 4: line_start four reads into the fetch of line 3.
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("part_addr", 32'(mem_addr), 24 + i);
      tick();
    end
    chk("pre_underrun", 32'(underrun), 0);
    next_line  = 2'd2;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("refetch_addr", 32'(mem_addr), 16 + i);
      chk("underrun_sticky", 32'(underrun), 1);
      tick();
    end
    tick();

    // 5: inactive lines: no reads, writes always allowed, banks still swap.
    swap_idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("inactive_ready", 32'(wr_ready), 1);
      chk("inactive_we", 32'(mem_we), 0);
      tick();
    end
    read_px(3'd3, 8'd19);
    swap_idle();
    read_px(3'd0, 8'd24);
    read_px(3'd3, 8'd3);
    chk("underrun_hold", 32'(underrun), 1);

    // 6: reset in the middle of a fetch.
    next_line        = 2'd1;
    next_line_active = 1'b1;
    line_start       = 1'b1;
    tick();
    line_start = 1'b0;
    disp_x     = 3'd0;
    tick();
    chk("pre_rst_pixel", 32'(disp_pixel), 16);
    chk("pre_rst_addr", 32'(mem_addr), 9);
    wr_valid = 1'b1;
    rst_n    = 1'b0;
    #1;
    chk("mid_rst_addr", 32'(mem_addr), 0);
    chk("mid_rst_we", 32'(mem_we), 0);
    chk("mid_rst_ready", 32'(wr_ready), 0);
    chk("mid_rst_pixel", 32'(disp_pixel), 0);
    chk("mid_rst_underrun", 32'(underrun), 0);
    tick();
    wr_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    chk("post_rst_ready", 32'(wr_ready), 1);
    chk("post_rst_we", 32'(mem_we), 0);
    tick();
    chk("post_rst_we2", 32'(mem_we), 0);
    chk("post_rst_addr", 32'(mem_addr), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
